// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - prescaled up/down one-shot/periodic timer with one-cycle done pulse
// Optional prescaler: define TIMER_COUNTER_PRESCALER_EN to build it; otherwise presc is ignored.
module timer_counter #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       load,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   periodic,
    input  logic                   down,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] load_q, load_q_n;
    logic             periodic_q, periodic_q_n;
    logic             down_q, down_q_n;
    logic             done_n;
    logic             start_acc;
    logic             tick;
    logic             terminal;

`ifdef TIMER_COUNTER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc_q, presc_q_n;
    logic [PRESC_WIDTH-1:0] presc_cnt, presc_cnt_n;

    assign tick = (state == RUN) && (presc_cnt == presc_q);
`else
    logic unused_presc;

    assign unused_presc = ^presc;
    assign tick         = (state == RUN);
`endif

    assign start_acc = start && !stop;
    // Terminal compare comes before any step, so the counter can never wrap.
    assign terminal  = tick && (down_q ? (count == '0) : (count == load_q));
    assign busy      = (state == RUN);

    always_comb begin
        state_n      = state;
        count_n      = count;
        load_q_n     = load_q;
        periodic_q_n = periodic_q;
        down_q_n     = down_q;
        done_n       = 1'b0;
`ifdef TIMER_COUNTER_PRESCALER_EN
        presc_q_n    = presc_q;
        presc_cnt_n  = presc_cnt;
`endif
        if (stop) begin
            state_n = IDLE;
        end else if (start_acc) begin
            load_q_n     = load;
            periodic_q_n = periodic;
            down_q_n     = down;
            count_n      = down ? load : '0;
            state_n      = RUN;
`ifdef TIMER_COUNTER_PRESCALER_EN
            presc_q_n    = presc;
            presc_cnt_n  = '0;
`endif
        end else if (state == RUN) begin
`ifdef TIMER_COUNTER_PRESCALER_EN
            presc_cnt_n = tick ? '0 : presc_cnt + PRESC_WIDTH'(1);
`endif
            if (terminal) begin
                done_n = 1'b1;
                if (periodic_q) begin
                    count_n = down_q ? load_q : '0;
                end else begin
                    count_n = '0;
                    state_n = IDLE;
                end
            end else if (tick) begin
                count_n = down_q ? count - WIDTH'(1) : count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            done       <= 1'b0;
            load_q     <= '0;
            periodic_q <= 1'b0;
            down_q     <= 1'b0;
`ifdef TIMER_COUNTER_PRESCALER_EN
            presc_q    <= '0;
            presc_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            count      <= count_n;
            done       <= done_n;
            load_q     <= load_q_n;
            periodic_q <= periodic_q_n;
            down_q     <= down_q_n;
`ifdef TIMER_COUNTER_PRESCALER_EN
            presc_q    <= presc_q_n;
            presc_cnt  <= presc_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - randomized self-checking bench for timer_counter
module tb_timer_counter;

    localparam int WIDTH       = 32;
    localparam int PRESC_WIDTH = 8;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       load;
    logic                   start;
    logic                   stop;
    logic                   periodic;
    logic                   down;
    logic [PRESC_WIDTH-1:0] presc;
    logic [WIDTH-1:0]       count;
    logic                   busy;
    logic                   done;

    int total;
    int bad;

    timer_counter #(.WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .down     (down),
        .presc    (presc),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {count, busy, done} k edges after the start edge, from period arithmetic.
    function automatic logic [WIDTH+1:0] model(input longint k, input longint ld,
                                               input bit per, input bit dn, input longint p);
        longint ep, period, ticks, ph;
        logic [WIDTH-1:0] c;
        logic b, d;
`ifdef TIMER_COUNTER_PRESCALER_EN
        ep = p;
`else
        ep = 0;
`endif
        period = (ld + 1) * (ep + 1);
        ticks  = k / (ep + 1);
        if (per) begin
            ph = ticks % (ld + 1);
            c  = WIDTH'(dn ? ld - ph : ph);
            b  = 1'b1;
            d  = (k > 0) && (k % period == 0);
        end else if (k < period) begin
            c = WIDTH'(dn ? ld - ticks : ticks);
            b = 1'b1;
            d = 1'b0;
        end else begin
            c = '0;
            b = 1'b0;
            d = (k == period);
        end
        return {c, b, d};
    endfunction

    // Caller is just after a negedge; returns just after the negedge following the start edge.
    task automatic do_start(input logic [WIDTH-1:0] ld, input bit per, input bit dn,
                            input logic [PRESC_WIDTH-1:0] ps);
        load = ld; periodic = per; down = dn; presc = ps; start = 1'b1; stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = '0; start = 1'b0; stop = 1'b0;
        periodic = 1'b0; down = 1'b0; presc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({count, busy, done} !== {{WIDTH{1'b0}}, 2'b00}) begin
            bad++;
            $display("FAIL reset: got count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
        end
    endtask

    task automatic test_up_oneshot();
        logic [WIDTH+1:0] exp;
        do_start(3, 1'b0, 1'b0, 0);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(negedge clk);
            exp = model(k, 3, 1'b0, 1'b0, 0);
            total++;
            if ({count, busy, done} !== exp) begin
                bad++;
                $display("FAIL up_oneshot k=%0d: got %0d/%b/%b want %0d/%b/%b", k,
                         count, busy, done, exp[WIDTH+1:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_down_periodic();
        logic [WIDTH+1:0] exp;
        do_start(2, 1'b1, 1'b1, 1);
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            exp = model(k, 2, 1'b1, 1'b1, 1);
            total++;
            if ({count, busy, done} !== exp) begin
                bad++;
                $display("FAIL down_periodic k=%0d: got %0d/%b/%b want %0d/%b/%b", k,
                         count, busy, done, exp[WIDTH+1:2], exp[1], exp[0]);
            end
        end
        go_idle();
    endtask

    task automatic test_stop_with_start();
        do_start(10, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        total++;
        if (count !== 5) begin
            bad++;
            $display("FAIL stop_pre: got count=%0d want 5", count);
        end
        load = 99; start = 1'b1; stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if ({count, busy, done} !== {WIDTH'(5), 2'b00}) begin
                bad++;
                $display("FAIL stop_hold k=%0d: got %0d/%b/%b want 5/0/0", k, count, busy, done);
            end
        end
    endtask

    task automatic test_restart();
        logic [WIDTH+1:0] exp;
        int dones;
        do_start(10, 1'b0, 1'b0, 0);
        repeat (7) @(negedge clk);
        total++;
        if (count !== 7) begin
            bad++;
            $display("FAIL restart_pre: got count=%0d want 7", count);
        end
        do_start(10, 1'b0, 1'b0, 0);
        dones = 0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(negedge clk);
            exp = model(k, 10, 1'b0, 1'b0, 0);
            dones += int'(done);
            total++;
            if ({count, busy, done} !== exp) begin
                bad++;
                $display("FAIL restart k=%0d: got %0d/%b/%b want %0d/%b/%b", k,
                         count, busy, done, exp[WIDTH+1:2], exp[1], exp[0]);
            end
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL restart_dones: got %0d want 1", dones);
        end
    endtask

    task automatic test_load_zero();
        do_start(0, 1'b1, 1'b0, 0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if ({count, busy, done} !== {{WIDTH{1'b0}}, 1'b1, (k > 0)}) begin
                bad++;
                $display("FAIL load_zero k=%0d: got %0d/%b/%b want 0/1/%b", k,
                         count, busy, done, (k > 0));
            end
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        logic [WIDTH+1:0] exp;
        do_start(6, 1'b1, 1'b1, 2);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({count, busy, done} !== {{WIDTH{1'b0}}, 2'b00}) begin
            bad++;
            $display("FAIL async_reset: got %0d/%b/%b want 0/0/0", count, busy, done);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        do_start(3, 1'b0, 1'b0, 5);
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) @(negedge clk);
            exp = model(k, 3, 1'b0, 1'b0, 5);
            total++;
            if ({count, busy, done} !== exp) begin
                bad++;
                $display("FAIL after_reset k=%0d: got %0d/%b/%b want %0d/%b/%b", k,
                         count, busy, done, exp[WIDTH+1:2], exp[1], exp[0]);
            end
        end
    endtask

    // Random settings, random input noise while running, optional stop at a random edge.
    task automatic test_random();
        logic [WIDTH+1:0] exp;
        logic [WIDTH+1:0] held;
        longint ld, ps, period, n, s;
        bit per, dn, use_stop;
        for (int it = 0; it < 8; it++) begin
            ld  = $urandom_range(0, 6);
            ps  = $urandom_range(0, 3);
            per = 1'($urandom);
            dn  = 1'($urandom);
            use_stop = 1'($urandom);
`ifdef TIMER_COUNTER_PRESCALER_EN
            period = (ld + 1) * (ps + 1);
`else
            period = ld + 1;
`endif
            n = 2 * period + 3;
            s = use_stop ? longint'($urandom_range(1, 32'(n - 1))) : n + 10;
            do_start(WIDTH'(ld), per, dn, PRESC_WIDTH'(ps));
            held = '0;
            for (longint k = 0; k <= n; k++) begin
                if (k > 0) @(negedge clk);
                stop = 1'b0;
                if (k < s) begin
                    exp = model(k, ld, per, dn, ps);
                    held = {exp[WIDTH+1:2], 2'b00};
                end else begin
                    exp = held;
                end
                total++;
                if ({count, busy, done} !== exp) begin
                    bad++;
                    $display("FAIL random it=%0d k=%0d: got %0d/%b/%b want %0d/%b/%b", it, k,
                             count, busy, done, exp[WIDTH+1:2], exp[1], exp[0]);
                end
                load = $urandom; periodic = 1'($urandom); down = 1'($urandom);
                presc = PRESC_WIDTH'($urandom);
                if (k + 1 == s) stop = 1'b1;
            end
            stop = 1'b0;
            go_idle();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_up_oneshot();
        test_down_periodic();
        test_stop_with_start();
        test_restart();
        test_load_zero();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Parametrised general-purpose timer. Counts up to, or down from, a latched load value at a programmable prescaled rate and raises a one-cycle `done` pulse at the terminal count. It runs in one-shot or periodic (auto-reload) mode and supports abort and restart. It sits on the peripheral side of the SoC as the timebase for polling delays, periodic inference triggers and timeouts.

## Interface
Parameters:
- `WIDTH`, 32: counter and load width in bits (≥2).
- `PRESC_WIDTH`, 8: prescaler divisor width in bits (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in WIDTH: terminal value (up) or start value (down); sampled only on accepted `start`.
- `start` in 1: level-sampled start/restart request.
- `stop` in 1: abort request.
- `periodic` in 1: 1 = auto-reload, 0 = one-shot; sampled on accepted `start`.
- `down` in 1: 1 = count down, 0 = count up; sampled on accepted `start`.
- `presc` in PRESC_WIDTH: tick every `presc`+1 clocks; sampled on accepted `start`.
- `count` out WIDTH: current count.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on terminal count.

## Operation
- States: IDLE, RUN. Reset → IDLE with `count`=0, `busy`=0, `done`=0, prescaler=0, all latched settings=0.
- Accepted `start` (`start`=1, `stop`=0, any state): latch `load`, `periodic`, `down`, `presc`; `count` ← `load` if down else 0; prescaler ← 0; → RUN. In RUN this is a restart; any pending terminal event is discarded and `done` stays 0.
- `stop`=1 always wins over `start`: → IDLE, `count` holds its value, no `done`. `stop` in IDLE has no effect.
- In RUN, a tick occurs on each edge where prescaler == latched `presc`; prescaler then wraps to 0, otherwise it increments.
- On a tick:
  - Up: if `count` == latched load, this is terminal; else `count`+1.
  - Down: if `count` == 0, this is terminal; else `count`−1.
- On terminal: `done` ← 1 for exactly one cycle.
  - Periodic: `count` ← reload value (0 up / load down) and stay in RUN.
  - One-shot: `count` ← 0, → IDLE.
- `load` = 0: terminal on the first tick in both directions (period is 1 tick).
- Inputs other than `start`/`stop` are ignored in RUN until the next accepted `start`.
- No arithmetic wrap is possible; the terminal compare precedes every increment or decrement.

## Timing
- Accepted `start` at edge N: `busy`=1 and initial `count` visible after N.
- First tick at edge N+`presc`+1; each subsequent tick follows `presc`+1 edges later.
- Terminal event on tick number `load`+1 after start, i.e. at edge N+(`load`+1)(`presc`+1). `done` is high for the following cycle only. `busy` falls at the same edge (one-shot).
- Periodic: `done` pulses every (`load`+1)(`presc`+1) clocks with no gap cycle.
- `stop` at edge M: `busy`=0 after M; a terminal tick coinciding with `stop` is suppressed.
- `rst_n` low mid-run: immediate return to reset values, independent of `clk`.

## Configuration
- `TIMER_COUNTER_PRESCALER_EN`:
  - Defined: prescaler implemented as described.
  - Undefined: the `presc` port remains but is ignored, no prescaler register is built, and every RUN edge is a tick (equivalent to `presc`=0).

## Test plan
- Up, one-shot, `load`=3, `presc`=0, start at edge N → `count` 0,1,2,3, then 0 with `done`=1 in the cycle after N+4 only; `busy` low from N+4.
- Down, periodic, `load`=2, `presc`=1 → `count` 2,2,1,1,0,0,2…; `done` every 6 clocks; `busy` stays 1 until `stop`.
- `start` and `stop` asserted together mid-run with `count`=5 → IDLE, `count` holds 5, no `done`.
- Restart at `count`=7 of `load`=10 up → `count` becomes 0, terminal 11 ticks later, single `done`.
- `load`=0, up, `presc`=0, periodic → `done` high every cycle from N+1, `count` stays 0.
- `rst_n` pulsed low between clock edges during RUN → outputs zero immediately; next `start` behaves normally. Repeat this case with the macro undefined: `presc`=5 ignored, ticks every clock.
